// File: rtl/execute_stage.sv
// EX stage: single-cycle ALU or 32-step shift-add multiply, registered into the EX/MEM boundary.
// ex_stall holds ID/EX while a multiply is in flight; bubbles carry no memory/writeback control.
module execute_stage #(
    parameter int DATA     = 32,
    parameter int REG_ADDR = 5,
    parameter int OPW      = 4
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [OPW-1:0]      alu_op,
    input  logic [DATA-1:0]     operand_a,
    input  logic [DATA-1:0]     operand_b,
    input  logic [DATA-1:0]     store_data,
    input  logic [REG_ADDR-1:0] dest_reg,
    input  logic                mem_read_in,
    input  logic                mem_write_in,
    input  logic                reg_write_in,
    input  logic                flush,
    output logic                ex_stall,
    output logic                out_valid,
    output logic [DATA-1:0]     out_address,
    output logic [DATA-1:0]     out_write_data,
    output logic [DATA-1:0]     out_wb_data,
    output logic                out_mem_read,
    output logic                out_mem_write,
    output logic                out_reg_write,
    output logic [REG_ADDR-1:0] out_dest_reg
);

    localparam int CW = $clog2(DATA);

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_AND = OPW'(2);
    localparam logic [OPW-1:0] OP_OR  = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] OP_SLT = OPW'(5);
    localparam logic [OPW-1:0] OP_SLL = OPW'(6);
    localparam logic [OPW-1:0] OP_SRL = OPW'(7);
    localparam logic [OPW-1:0] OP_MUL = OPW'(8);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA-1:0]     mul_a_q, mul_a_d;
    logic [DATA-1:0]     mul_b_q, mul_b_d;
    logic [DATA-1:0]     acc_q, acc_d;
    logic [DATA-1:0]     cap_wdata_q, cap_wdata_d;
    logic [REG_ADDR-1:0] cap_dest_q, cap_dest_d;
    logic                cap_rd_q, cap_rd_d;
    logic                cap_wr_q, cap_wr_d;
    logic                cap_rw_q, cap_rw_d;

    logic                valid_q, valid_d;
    logic [DATA-1:0]     res_q, res_d;
    logic [DATA-1:0]     wdata_q, wdata_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                rw_q, rw_d;
    logic [REG_ADDR-1:0] dest_q, dest_d;

    logic [DATA-1:0]     alu_res;
    logic [DATA-1:0]     mul_step;
    logic                accept;

    assign ex_stall = (state_q == BUSY);
    assign accept   = in_valid & ~ex_stall & ~flush;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = operand_a + operand_b;
            OP_SUB:  alu_res = operand_a - operand_b;
            OP_AND:  alu_res = operand_a & operand_b;
            OP_OR:   alu_res = operand_a | operand_b;
            OP_XOR:  alu_res = operand_a ^ operand_b;
            OP_SLT:  alu_res = {{(DATA-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            OP_SLL:  alu_res = operand_a << operand_b[4:0];
            OP_SRL:  alu_res = operand_a >> operand_b[4:0];
            default: alu_res = '0;
        endcase
    end

    // A shifts right and B shifts left, so bit i of A always sits in mul_a_q[0].
    assign mul_step = acc_q + (mul_a_q[0] ? mul_b_q : '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        acc_d       = acc_q;
        cap_wdata_d = cap_wdata_q;
        cap_dest_d  = cap_dest_q;
        cap_rd_d    = cap_rd_q;
        cap_wr_d    = cap_wr_q;
        cap_rw_d    = cap_rw_q;
        valid_d     = 1'b0;
        res_d       = res_q;
        wdata_d     = wdata_q;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        rw_d        = 1'b0;
        dest_d      = dest_q;

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (alu_op == OP_MUL) begin
                            mul_a_d     = operand_a;
                            mul_b_d     = operand_b;
                            acc_d       = '0;
                            cap_wdata_d = store_data;
                            cap_dest_d  = dest_reg;
                            cap_rd_d    = mem_read_in;
                            cap_wr_d    = mem_write_in;
                            cap_rw_d    = reg_write_in;
                            cnt_d       = CW'(DATA - 1);
                            state_d     = BUSY;
                        end else begin
                            valid_d = 1'b1;
                            res_d   = alu_res;
                            wdata_d = store_data;
                            dest_d  = dest_reg;
                            rd_d    = mem_read_in;
                            wr_d    = mem_write_in;
                            rw_d    = reg_write_in;
                        end
                    end
                end
                BUSY: begin
                    acc_d   = mul_step;
                    mul_a_d = mul_a_q >> 1;
                    mul_b_d = mul_b_q << 1;
                    cnt_d   = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        valid_d = 1'b1;
                        res_d   = mul_step;
                        wdata_d = cap_wdata_q;
                        dest_d  = cap_dest_q;
                        rd_d    = cap_rd_q;
                        wr_d    = cap_wr_q;
                        rw_d    = cap_rw_q;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            acc_q       <= '0;
            cap_wdata_q <= '0;
            cap_dest_q  <= '0;
            cap_rd_q    <= 1'b0;
            cap_wr_q    <= 1'b0;
            cap_rw_q    <= 1'b0;
            valid_q     <= 1'b0;
            res_q       <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rw_q        <= 1'b0;
            dest_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            acc_q       <= acc_d;
            cap_wdata_q <= cap_wdata_d;
            cap_dest_q  <= cap_dest_d;
            cap_rd_q    <= cap_rd_d;
            cap_wr_q    <= cap_wr_d;
            cap_rw_q    <= cap_rw_d;
            valid_q     <= valid_d;
            res_q       <= res_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            rw_q        <= rw_d;
            dest_q      <= dest_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_address    = res_q;
    assign out_wb_data    = res_q;
    assign out_write_data = wdata_q;
    assign out_mem_read   = rd_q;
    assign out_mem_write  = wr_q;
    assign out_reg_write  = rw_q;
    assign out_dest_reg   = dest_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: inputs change on the falling edge, outputs are checked there too.
module tb_execute_stage;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4;
    localparam logic [3:0] SLT = 4'd5, SLL = 4'd6, SRL = 4'd7, MUL = 4'd8;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  alu_op = '0;
    logic [31:0] operand_a = '0, operand_b = '0, store_data = '0;
    logic [4:0]  dest_reg = '0;
    logic        mem_read_in = 1'b0, mem_write_in = 1'b0, reg_write_in = 1'b0, flush = 1'b0;

    logic        ex_stall, out_valid, out_mem_read, out_mem_write, out_reg_write;
    logic [31:0] out_address, out_write_data, out_wb_data;
    logic [4:0]  out_dest_reg;

    int tests_run = 0;
    int fails = 0;

    execute_stage dut (
        .clock(clock), .rst(rst), .in_valid(in_valid), .alu_op(alu_op),
        .operand_a(operand_a), .operand_b(operand_b), .store_data(store_data),
        .dest_reg(dest_reg), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .reg_write_in(reg_write_in), .flush(flush), .ex_stall(ex_stall),
        .out_valid(out_valid), .out_address(out_address), .out_write_data(out_write_data),
        .out_wb_data(out_wb_data), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_reg_write(out_reg_write), .out_dest_reg(out_dest_reg)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] sd, input logic [4:0] d, input logic rd, input logic wr,
                         input logic rw);
        in_valid = v; alu_op = op; operand_a = a; operand_b = b; store_data = sd;
        dest_reg = d; mem_read_in = rd; mem_write_in = wr; reg_write_in = rw;
    endtask

    task automatic idle();
        drive(1'b0, ADD, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [105:0] obs;
        rst = 1'b1; idle();
        repeat (2) @(negedge clock);
        obs = {out_valid, out_address, out_write_data, out_wb_data, out_mem_read, out_mem_write,
               out_reg_write, out_dest_reg, ex_stall};
        tests_run++;
        if (obs !== '0) begin fails++; $display("FAIL por_outputs got=%h want=0", obs); end
        rst = 1'b0;
        drive(1'b1, ADD, 32'h12345678, 32'h11111111, 32'hCAFEF00D, 5'd7, 1'b0, 1'b1, 1'b1);
        @(negedge clock);
        tests_run++;
        if ({out_valid, out_wb_data} !== {1'b1, 32'h23456789}) begin
            fails++; $display("FAIL pre_reset_add got=%b/%h want=1/23456789", out_valid, out_wb_data);
        end
        drive(1'b1, MUL, 32'd3, 32'd4, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1);
        @(negedge clock); idle();
        repeat (3) @(negedge clock);
        tests_run++;
        if (ex_stall !== 1'b1) begin fails++; $display("FAIL pre_reset_stall got=%b want=1", ex_stall); end
        #2 rst = 1'b1;
        #1;
        obs = {out_valid, out_address, out_write_data, out_wb_data, out_mem_read, out_mem_write,
               out_reg_write, out_dest_reg, ex_stall};
        tests_run++;
        if (obs !== '0) begin fails++; $display("FAIL async_reset got=%h want=0", obs); end
        @(negedge clock); rst = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({ex_stall, out_valid} !== 2'b00) begin
            fails++; $display("FAIL post_reset_idle got=%b%b want=00", ex_stall, out_valid);
        end
    endtask

    task automatic test_add();
        drive(1'b1, ADD, 32'h7FFFFFFF, 32'h1, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1);
        @(negedge clock); idle();
        tests_run++;
        if ({out_valid, out_reg_write, out_mem_write, out_wb_data, out_address, out_dest_reg} !==
            {1'b1, 1'b1, 1'b0, 32'h80000000, 32'h80000000, 5'd5}) begin
            fails++;
            $display("FAIL add_wrap got v=%b rw=%b mw=%b wb=%h addr=%h d=%0d want 1 1 0 80000000 80000000 5",
                     out_valid, out_reg_write, out_mem_write, out_wb_data, out_address, out_dest_reg);
        end
        @(negedge clock);
        tests_run++;
        if ({out_valid, out_reg_write, out_wb_data} !== {1'b0, 1'b0, 32'h80000000}) begin
            fails++; $display("FAIL add_bubble got v=%b rw=%b wb=%h want 0 0 80000000",
                              out_valid, out_reg_write, out_wb_data);
        end
    endtask

    task automatic test_store();
        drive(1'b1, ADD, 32'h100, 32'h4, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clock); idle();
        tests_run++;
        if ({out_valid, out_mem_write, out_reg_write, out_address, out_write_data} !==
            {1'b1, 1'b1, 1'b0, 32'h104, 32'hDEADBEEF}) begin
            fails++; $display("FAIL store got v=%b mw=%b rw=%b addr=%h wd=%h want 1 1 0 104 deadbeef",
                              out_valid, out_mem_write, out_reg_write, out_address, out_write_data);
        end
        @(negedge clock);
        tests_run++;
        if ({out_valid, out_mem_write} !== 2'b00) begin
            fails++; $display("FAIL store_one_cycle got v=%b mw=%b want 0 0", out_valid, out_mem_write);
        end
    endtask

    task automatic test_mul();
        int bad;
        int n;
        logic seen;
        drive(1'b1, MUL, 32'd7, 32'd6, 32'h55, 5'd9, 1'b0, 1'b0, 1'b1);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            if (i == 0) drive(1'b1, ADD, 32'd1, 32'd2, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1);
            if ({ex_stall, out_valid} !== 2'b10) bad++;
        end
        tests_run++;
        if (bad != 0) begin fails++; $display("FAIL mul_stall_window got=%0d bad cycles want=0", bad); end
        @(negedge clock);
        tests_run++;
        if ({ex_stall, out_valid, out_reg_write, out_wb_data, out_dest_reg} !==
            {1'b0, 1'b1, 1'b1, 32'd42, 5'd9}) begin
            fails++; $display("FAIL mul_result got st=%b v=%b rw=%b wb=%h d=%0d want 0 1 1 2a 9",
                              ex_stall, out_valid, out_reg_write, out_wb_data, out_dest_reg);
        end
        @(negedge clock); idle();
        tests_run++;
        if ({out_valid, out_wb_data, out_dest_reg} !== {1'b1, 32'd3, 5'd3}) begin
            fails++; $display("FAIL add_after_mul got v=%b wb=%h d=%0d want 1 3 3",
                              out_valid, out_wb_data, out_dest_reg);
        end
        drive(1'b1, MUL, 32'h10001, 32'h10001, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1);
        @(negedge clock); idle();
        seen = 1'b0; n = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (out_valid === 1'b1) begin seen = 1'b1; n = i + 1; end
        end
        tests_run++;
        if (!seen || n != 32 || out_wb_data !== 32'h00020001) begin
            fails++; $display("FAIL mul_wrap got seen=%b lat=%0d wb=%h want 1 32 00020001",
                              seen, n, out_wb_data);
        end
    endtask

    task automatic test_flush();
        int bad;
        drive(1'b1, MUL, 32'd5, 32'd3, 32'h0, 5'd6, 1'b0, 1'b0, 1'b1);
        @(negedge clock); idle();
        repeat (9) @(negedge clock);
        flush = 1'b1;
        drive(1'b1, ADD, 32'd1, 32'd1, 32'h0, 5'd1, 1'b0, 1'b1, 1'b1);
        @(negedge clock);
        flush = 1'b0; idle();
        tests_run++;
        if ({ex_stall, out_valid, out_mem_write, out_reg_write} !== 4'b0000) begin
            fails++; $display("FAIL flush_abort got st=%b v=%b mw=%b rw=%b want 0 0 0 0",
                              ex_stall, out_valid, out_mem_write, out_reg_write);
        end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (out_valid !== 1'b0 || ex_stall !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin fails++; $display("FAIL flush_no_result got=%0d bad cycles want=0", bad); end
        drive(1'b1, ADD, 32'd10, 32'd20, 32'h0, 5'd8, 1'b0, 1'b0, 1'b1);
        @(negedge clock); idle();
        tests_run++;
        if ({out_valid, out_wb_data, out_dest_reg} !== {1'b1, 32'd30, 5'd8}) begin
            fails++; $display("FAIL add_after_flush got v=%b wb=%h d=%0d want 1 1e 8",
                              out_valid, out_wb_data, out_dest_reg);
        end
    endtask

    task automatic test_alu_table();
        logic [3:0]  t_op  [10];
        logic [31:0] t_a   [10];
        logic [31:0] t_b   [10];
        logic [31:0] t_exp [10];
        t_op[0] = SUB;   t_a[0] = 32'h0;        t_b[0] = 32'h1;        t_exp[0] = 32'hFFFFFFFF;
        t_op[1] = AND_;  t_a[1] = 32'hF0F0F0F0; t_b[1] = 32'hFF00FF00; t_exp[1] = 32'hF000F000;
        t_op[2] = OR_;   t_a[2] = 32'hF0F0F0F0; t_b[2] = 32'h0F0F0000; t_exp[2] = 32'hFFFFF0F0;
        t_op[3] = XOR_;  t_a[3] = 32'hFFFF0000; t_b[3] = 32'h0F0F0F0F; t_exp[3] = 32'hF0F00F0F;
        t_op[4] = SLT;   t_a[4] = 32'hFFFFFFFF; t_b[4] = 32'h1;        t_exp[4] = 32'h1;
        t_op[5] = SLT;   t_a[5] = 32'h1;        t_b[5] = 32'hFFFFFFFF; t_exp[5] = 32'h0;
        t_op[6] = SLL;   t_a[6] = 32'h1;        t_b[6] = 32'h24;       t_exp[6] = 32'h10;
        t_op[7] = SRL;   t_a[7] = 32'h80000000; t_b[7] = 32'd31;       t_exp[7] = 32'h1;
        t_op[8] = 4'd12; t_a[8] = 32'h5;        t_b[8] = 32'h6;        t_exp[8] = 32'h0;
        t_op[9] = ADD;   t_a[9] = 32'hFFFFFFFF; t_b[9] = 32'h2;        t_exp[9] = 32'h1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, t_op[i], t_a[i], t_b[i], 32'h0, 5'(i), 1'b0, 1'b0, 1'b1);
            @(negedge clock);
            tests_run++;
            if ({out_valid, out_wb_data} !== {1'b1, t_exp[i]}) begin
                fails++; $display("FAIL alu_row%0d op=%0d got v=%b res=%h want 1 %h",
                                  i, t_op[i], out_valid, out_wb_data, t_exp[i]);
            end
        end
        idle();
    endtask

    task automatic test_misc();
        drive(1'b1, 4'd12, 32'h5, 32'h6, 32'h77, 5'd11, 1'b1, 1'b0, 1'b1);
        @(negedge clock);
        tests_run++;
        if ({out_valid, out_mem_read, out_reg_write, out_wb_data, out_dest_reg} !==
            {1'b1, 1'b1, 1'b1, 32'h0, 5'd11}) begin
            fails++; $display("FAIL op12_ctrl got v=%b mr=%b rw=%b res=%h d=%0d want 1 1 1 0 11",
                              out_valid, out_mem_read, out_reg_write, out_wb_data, out_dest_reg);
        end
        drive(1'b0, ADD, 32'h1, 32'h1, 32'h99, 5'd12, 1'b0, 1'b1, 1'b1);
        @(negedge clock); idle();
        tests_run++;
        if ({out_valid, out_mem_write, out_reg_write, out_mem_read} !== 4'b0000) begin
            fails++; $display("FAIL invalid_no_write got v=%b mw=%b rw=%b mr=%b want 0 0 0 0",
                              out_valid, out_mem_write, out_reg_write, out_mem_read);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_store();
        test_mul();
        test_flush();
        test_alu_table();
        test_misc();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
